// File: rtl/count_block_ctrl_pkg.sv
// Shared types and defaults for the block-index sequencer and the interpolation top.
package count_block_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

    localparam int unsigned DefCntW      = 4;
    localparam int unsigned DefNumBlocks = 16;

endpackage

// File: rtl/count_block_reg.sv
// CNT_W-wide enable/load register holding the current block index.
module count_block_reg #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= load_val;
        end
    end

endmodule

// File: rtl/count_block_ctrl.sv
// Block-index sequencer: START/ADVANCE/ABORT control around a loadable index register.
// Optional continuous (wrapping) mode is enabled by defining COUNT_BLOCK_CTRL_WRAP_EN.
module count_block_ctrl
    import count_block_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned NUM_BLOCKS = DefNumBlocks
) (
    input  logic             CLK,
    input  logic             RST_ASYNC_N,
    input  logic             START,
    input  logic [CNT_W-1:0] FIRST_BLOCK,
    input  logic             ADVANCE,
    input  logic             ABORT,
    output logic [CNT_W-1:0] BLOCK_IDX,
    output logic             BUSY,
    output logic             LAST,
    output logic             DONE,
    output logic             ERR_START
);

    // One extra bit so NUM_BLOCKS == 2^CNT_W is representable in the range check.
    localparam logic [CNT_W:0]   NumBlk  = (CNT_W + 1)'(NUM_BLOCKS);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_BLOCKS - 1);

    state_e           state;
    logic             start_ok;
    logic             idx_en;
    logic [CNT_W-1:0] idx_d;
    logic [CNT_W-1:0] idx_inc;

    assign start_ok = ({1'b0, FIRST_BLOCK} < NumBlk);
    assign idx_inc  = BLOCK_IDX + CNT_W'(1);

    always_comb begin
        idx_en = 1'b0;
        idx_d  = BLOCK_IDX;
        case (state)
            StIdle: begin
                if (START && start_ok) begin
                    idx_en = 1'b1;
                    idx_d  = FIRST_BLOCK;
                end
            end
            StRun: begin
                if (!ABORT && ADVANCE) begin
                    if (!LAST) begin
                        idx_en = 1'b1;
                        idx_d  = idx_inc;
                    end
`ifdef COUNT_BLOCK_CTRL_WRAP_EN
                    else begin
                        idx_en = 1'b1;
                        idx_d  = '0;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    count_block_reg #(
        .CNT_W(CNT_W)
    ) u_idx_reg (
        .clk     (CLK),
        .rst_n   (RST_ASYNC_N),
        .en      (idx_en),
        .load_val(idx_d),
        .q       (BLOCK_IDX)
    );

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state     <= StIdle;
            BUSY      <= 1'b0;
            LAST      <= 1'b0;
            DONE      <= 1'b0;
            ERR_START <= 1'b0;
        end else begin
            DONE      <= 1'b0;
            ERR_START <= 1'b0;
            case (state)
                StIdle: begin
                    if (START) begin
                        if (start_ok) begin
                            state <= StRun;
                            BUSY  <= 1'b1;
                            LAST  <= (FIRST_BLOCK == LastIdx);
                        end else begin
                            ERR_START <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (ABORT) begin
                        state <= StFin;
                        BUSY  <= 1'b0;
                        LAST  <= 1'b0;
                        DONE  <= 1'b1;
                    end else if (ADVANCE) begin
                        if (LAST) begin
`ifdef COUNT_BLOCK_CTRL_WRAP_EN
                            DONE <= 1'b1;
                            LAST <= (LastIdx == '0);
`else
                            state <= StFin;
                            BUSY  <= 1'b0;
                            LAST  <= 1'b0;
                            DONE  <= 1'b1;
`endif
                        end else begin
                            LAST <= (idx_inc == LastIdx);
                        end
                    end
                end
                StFin: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    BUSY  <= 1'b0;
                    LAST  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_block_ctrl.sv
// Scoreboard bench for count_block_ctrl: three instances (16, 10 and 4 blocks).
module tb_count_block_ctrl;

    typedef struct packed {
        logic [3:0] idx;
        logic       busy;
        logic       last;
        logic       done;
        logic       err;
    } rec_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic [3:0] fb_v [3];
    logic [2:0] adv_v;
    logic [2:0] ab_v;
    logic [3:0] idx_v [3];
    logic [2:0] busy_v;
    logic [2:0] last_v;
    logic [2:0] done_v;
    logic [2:0] err_v;

    rec_t exp_q [3][$];
    int   checks;
    int   errors;

    count_block_ctrl #(.CNT_W(4), .NUM_BLOCKS(16)) dut0 (
        .CLK(clk), .RST_ASYNC_N(rst_n), .START(start_v[0]), .FIRST_BLOCK(fb_v[0]),
        .ADVANCE(adv_v[0]), .ABORT(ab_v[0]), .BLOCK_IDX(idx_v[0]), .BUSY(busy_v[0]),
        .LAST(last_v[0]), .DONE(done_v[0]), .ERR_START(err_v[0])
    );

    count_block_ctrl #(.CNT_W(4), .NUM_BLOCKS(10)) dut1 (
        .CLK(clk), .RST_ASYNC_N(rst_n), .START(start_v[1]), .FIRST_BLOCK(fb_v[1]),
        .ADVANCE(adv_v[1]), .ABORT(ab_v[1]), .BLOCK_IDX(idx_v[1]), .BUSY(busy_v[1]),
        .LAST(last_v[1]), .DONE(done_v[1]), .ERR_START(err_v[1])
    );

    count_block_ctrl #(.CNT_W(4), .NUM_BLOCKS(4)) dut2 (
        .CLK(clk), .RST_ASYNC_N(rst_n), .START(start_v[2]), .FIRST_BLOCK(fb_v[2]),
        .ADVANCE(adv_v[2]), .ABORT(ab_v[2]), .BLOCK_IDX(idx_v[2]), .BUSY(busy_v[2]),
        .LAST(last_v[2]), .DONE(done_v[2]), .ERR_START(err_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t obs(input int id);
        rec_t r;
        r.idx  = idx_v[id];
        r.busy = busy_v[id];
        r.last = last_v[id];
        r.done = done_v[id];
        r.err  = err_v[id];
        return r;
    endfunction

    function automatic rec_t mk(input logic [3:0] i, input logic b, input logic l,
                                input logic d, input logic e);
        rec_t r;
        r.idx  = i;
        r.busy = b;
        r.last = l;
        r.done = d;
        r.err  = e;
        return r;
    endfunction

    task automatic chk(input string name, input rec_t got, input rec_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got idx=%0d busy=%0b last=%0b done=%0b err=%0b, want idx=%0d busy=%0b last=%0b done=%0b err=%0b",
                     name, got.idx, got.busy, got.last, got.done, got.err,
                     want.idx, want.busy, want.last, want.done, want.err);
        end
    endtask

    // Monitor: any cycle with BUSY/DONE/ERR_START is an output event to be scored.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                rec_t o;
                o = obs(i);
                if (o.busy || o.done || o.err) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d_unexpected: got idx=%0d busy=%0b last=%0b done=%0b err=%0b, want no output",
                                 i, o.idx, o.busy, o.last, o.done, o.err);
                    end else begin
                        chk($sformatf("dut%0d_out", i), o, exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    // Drive one cycle on instance id; optionally expect an output event after the edge.
    task automatic cyc(input int id, input logic s, input logic [3:0] f, input logic a,
                       input logic b, input logic pres, input rec_t e);
        start_v = '0;
        adv_v   = '0;
        ab_v    = '0;
        start_v[id] = s;
        fb_v[id]    = f;
        adv_v[id]   = a;
        ab_v[id]    = b;
        if (pres) exp_q[id].push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int id, input int n);
        for (int k = 0; k < n; k++) cyc(id, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic drain(input int id, input string name);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q[id].size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d unserved expected events, want 0",
                     name, exp_q[id].size());
            exp_q[id].delete();
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start_v = '0;
        adv_v   = '0;
        ab_v    = '0;
        for (int i = 0; i < 3; i++) fb_v[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("reset_dut%0d", i), obs(i), '0);
        rst_n = 1'b1;
        idle(0, 2);

        // Reset mid-RUN: outputs clear immediately, no DONE afterwards.
        cyc(0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, mk(4'd5, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd6, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        adv_v = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_run", obs(0), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0, 3);
        drain(0, "reset_mid_run");

        // Full sequence from 0 with ADVANCE every cycle.
        cyc(0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 16; i++) begin
            if (i < 15)
                cyc(0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1,
                    mk(4'(i + 1), 1'b1, (i + 1 == 15), 1'b0, 1'b0));
            else
                cyc(0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd15, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        idle(0, 2);
        chk("idx_retained", obs(0), mk(4'd15, 1'b0, 1'b0, 1'b0, 1'b0));
        drain(0, "full_seq");

        // Start at 14, ADVANCE with 3-cycle gaps; ADVANCE/ABORT in IDLE ignored.
        cyc(0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, '0);
        cyc(0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b1, mk(4'd14, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
            cyc(0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(4'd14, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd15, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
            cyc(0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mk(4'd15, 1'b1, 1'b1, 1'b0, 1'b0));
        cyc(0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd15, 1'b0, 1'b0, 1'b1, 1'b0));
        idle(0, 2);
        drain(0, "gapped");

        // NUM_BLOCKS=10: illegal start, then start at the last index.
        cyc(1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b1, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        idle(1, 2);
        cyc(1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, mk(4'd9, 1'b1, 1'b1, 1'b0, 1'b0));
        cyc(1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd9, 1'b0, 1'b0, 1'b1, 1'b0));
        idle(1, 2);
        drain(1, "nb10");

        // ABORT beats ADVANCE; START during FIN ignored, next cycle accepted.
        cyc(0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, mk(4'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 4; i <= 6; i++)
            cyc(0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'(i), 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, mk(4'd6, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc(0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, '0);
        cyc(0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, mk(4'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, mk(4'd1, 1'b0, 1'b0, 1'b1, 1'b0));
        idle(0, 2);
        drain(0, "abort");

        // NUM_BLOCKS=4 from index 2.
        cyc(2, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, mk(4'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd3, 1'b1, 1'b1, 1'b0, 1'b0));
`ifdef COUNT_BLOCK_CTRL_WRAP_EN
        cyc(2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        cyc(2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        cyc(2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        cyc(2, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, mk(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
`else
        cyc(2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, mk(4'd3, 1'b0, 1'b0, 1'b1, 1'b0));
`endif
        idle(2, 2);
        drain(2, "nb4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
